// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory access controller.
//   SZ_B/SZ_H/SZ_W : m_size encodings (2'b11 behaves as a word access)
//   state_t        : controller FSM states
//   is_misaligned  : alignment check for a pipeline access of a given size
package rv_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_MERGE   = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = lane[0];
      default: mis = (lane != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane handling for sub-word accesses.
//   rd_word   : 32-bit word read from memory
//   lane      : byte address bits [1:0] (half accesses use lane[1] only)
//   size      : access size (SZ_B / SZ_H / word)
//   uns       : 1 = zero-extend loads, 0 = sign-extend
//   wdata     : right-justified store data
//   load_data : extracted and extended load result
//   merged    : rd_word with the addressed byte/half replaced by wdata
module dmem_lane_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word[{lane, 3'b000} +: 8];
    half_sel = rd_word[{lane[1], 4'b0000} +: 16];

    case (size)
      SZ_B:    load_data = uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    load_data = uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase

    merged = rd_word;
    case (size)
      SZ_B:    merged[{lane, 3'b000} +: 8]     = wdata[7:0];
      SZ_H:    merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Single-port data memory sequencer shared between the MEM stage (M) and a
// debug/DMA port (D). Byte/half stores become read-modify-write sequences;
// M and D are arbitrated round-robin, with M preferred out of reset.
//   clk, rst                : clock, async active-low reset
//   m_* (in)                : pipeline request, held stable until m_done
//   m_rdata/m_done/m_err    : load result, completion pulse, misalignment flag
//   m_stall                 : m_req & ~m_done
//   d_* (in)                : debug word request
//   d_ready/d_rvalid/d_rdata: accept strobe, read-data pulse, read data
//   mem_*                   : word-wide synchronous memory (1-cycle read)
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | arbitrate; issue word write, read, or nothing (misaligned)
// ST_RD_WAIT | memory read data valid; capture load result or RMW word
// ST_MERGE   | write back RMW word with new byte/half lane
// ST_ACK     | completion pulse to the owner; no grant in this cycle
module dmem_access_ctrl
  import rv_mem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 64,
  localparam int IDX         = $clog2(DEPTH_WORDS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           m_req,
  input  logic           m_we,
  input  logic [1:0]     m_size,
  input  logic           m_unsigned,
  input  logic [31:0]    m_addr,
  input  logic [31:0]    m_wdata,
  output logic [31:0]    m_rdata,
  output logic           m_done,
  output logic           m_err,
  output logic           m_stall,
  input  logic           d_valid,
  input  logic           d_we,
  input  logic [31:0]    d_addr,
  input  logic [31:0]    d_wdata,
  output logic           d_ready,
  output logic           d_rvalid,
  output logic [31:0]    d_rdata,
  output logic           mem_en,
  output logic           mem_we,
  output logic [IDX-1:0] mem_addr,
  output logic [31:0]    mem_wdata,
  input  logic [31:0]    mem_rdata
);

  state_t state, state_nx;

  // 0: M wins a tie, 1: D wins a tie
  logic           rr_prefer_d;

  logic           op_owner_d;
  logic           op_we;
  logic [1:0]     op_size;
  logic           op_uns;
  logic [1:0]     op_lane;
  logic [IDX-1:0] op_idx;
  logic [31:0]    op_wdata;
  logic           op_err;
  logic [31:0]    held_word;

  logic           idle_live;
  logic           grant_m, grant_d;
  logic           m_mis, m_sub, m_word_store;
  logic [31:0]    align_word, load_data, merged;

  // Grants are combinational in IDLE; gating with rst keeps every
  // request-driven output quiet while reset is held.
  assign idle_live    = (state == ST_IDLE) && rst;
  assign grant_m      = idle_live && m_req && (!d_valid || !rr_prefer_d);
  assign grant_d      = idle_live && d_valid && !grant_m;
  assign m_mis        = is_misaligned(m_size, m_addr[1:0]);
  assign m_sub        = (m_size == SZ_B) || (m_size == SZ_H);
  assign m_word_store = m_we && !m_sub;
  assign m_stall      = m_req && !m_done;

  // RD_WAIT extracts loads from the live read data; MERGE works on the
  // word captured during RD_WAIT.
  assign align_word = (state == ST_MERGE) ? held_word : mem_rdata;

  dmem_lane_align u_align (
    .rd_word   (align_word),
    .lane      (op_lane),
    .size      (op_size),
    .uns       (op_uns),
    .wdata     (op_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (grant_m)      state_nx = (m_mis || m_word_store) ? ST_ACK : ST_RD_WAIT;
        else if (grant_d) state_nx = d_we ? ST_ACK : ST_RD_WAIT;
      end
      ST_RD_WAIT: state_nx = op_we ? ST_MERGE : ST_ACK;
      ST_MERGE:   state_nx = ST_ACK;
      ST_ACK:     state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    m_done    = 1'b0;
    m_err     = 1'b0;
    d_ready   = 1'b0;
    d_rvalid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_m) begin
          if (!m_mis) begin
            mem_en    = 1'b1;
            mem_we    = m_word_store;
            mem_addr  = m_addr[IDX+1:2];
            mem_wdata = m_word_store ? m_wdata : '0;
          end
        end else if (grant_d) begin
          d_ready   = 1'b1;
          mem_en    = 1'b1;
          mem_we    = d_we;
          mem_addr  = d_addr[IDX+1:2];
          mem_wdata = d_we ? d_wdata : '0;
        end
      end
      ST_MERGE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = op_idx;
        mem_wdata = merged;
      end
      ST_ACK: begin
        m_done   = !op_owner_d;
        m_err    = !op_owner_d && op_err;
        d_rvalid = op_owner_d && !op_we;
      end
      default: ;
    endcase
  end

  // Operation fields are latched at grant so an (illegal) mid-operation
  // drop of the request cannot corrupt the remaining steps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_prefer_d <= 1'b0;
      op_owner_d  <= 1'b0;
      op_we       <= 1'b0;
      op_size     <= SZ_B;
      op_uns      <= 1'b0;
      op_lane     <= 2'b00;
      op_idx      <= '0;
      op_wdata    <= '0;
      op_err      <= 1'b0;
      held_word   <= '0;
      m_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      if (grant_m) begin
        rr_prefer_d <= 1'b1;
        op_owner_d  <= 1'b0;
        op_we       <= m_we;
        op_size     <= m_size;
        op_uns      <= m_unsigned;
        op_lane     <= m_addr[1:0];
        op_idx      <= m_addr[IDX+1:2];
        op_wdata    <= m_wdata;
        op_err      <= m_mis;
      end else if (grant_d) begin
        rr_prefer_d <= 1'b0;
        op_owner_d  <= 1'b1;
        op_we       <= d_we;
        op_size     <= SZ_W;
        op_uns      <= 1'b0;
        op_lane     <= 2'b00;
        op_idx      <= d_addr[IDX+1:2];
        op_wdata    <= d_wdata;
        op_err      <= 1'b0;
      end
      if (state == ST_RD_WAIT) begin
        if (op_we)           held_word <= mem_rdata;
        else if (op_owner_d) d_rdata   <= mem_rdata;
        else                 m_rdata   <= load_data;
      end
    end
  end

  // Upper address bits wrap; debug byte-offset bits carry no meaning.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m_addr[31:IDX+2], d_addr[31:IDX+2], d_addr[1:0]};

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural word memory.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_req, m_we, m_unsigned;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_done, m_err, m_stall;
  logic        d_valid, d_we;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_ready, d_rvalid;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [0:63];
  int          wr_count = 0;

  int total = 0;
  int bad   = 0;

  // values sampled by the op tasks
  logic        g_en, g_we, g_stall, g_err, g_ready, g_rv1, g_rv2, g_done1;
  logic [5:0]  g_addr;
  logic [31:0] g_wdata, g_rdata;
  int          lat;
  int          wrb;

  dmem_access_ctrl #(.DEPTH_WORDS(64)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_unsigned(m_unsigned),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_done(m_done),
    .m_err(m_err), .m_stall(m_stall),
    .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one pipeline access from IDLE; lat = cycles from grant to m_done.
  task automatic m_op(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd);
    tick();
    m_req = 1'b1; m_we = we; m_size = sz; m_unsigned = uns; m_addr = addr; m_wdata = wd;
    #1;
    g_en = mem_en; g_we = mem_we; g_addr = mem_addr; g_wdata = mem_wdata; g_stall = m_stall;
    lat = 0;
    while (!m_done && lat < 10) begin
      tick(); #1;
      lat++;
    end
    g_err   = m_err;
    g_rdata = m_rdata;
    m_req   = 1'b0;
  endtask

  // Debug access: grant cycle, then the two following cycles are sampled.
  task automatic d_op(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    tick();
    d_valid = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    #1;
    g_ready = d_ready; g_en = mem_en; g_we = mem_we; g_addr = mem_addr; g_wdata = mem_wdata;
    tick();
    d_valid = 1'b0;
    #1;
    g_rv1 = d_rvalid; g_done1 = m_done;
    tick(); #1;
    g_rv2 = d_rvalid;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    m_req = 0; m_we = 0; m_size = 2'b10; m_unsigned = 0; m_addr = '0; m_wdata = '0;
    d_valid = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    #2;
    check("rst mem_en",   mem_en, 0);
    check("rst mem_we",   mem_we, 0);
    check("rst m_done",   m_done, 0);
    check("rst d_ready",  d_ready, 0);
    check("rst m_rdata",  m_rdata, 0);
    check("rst d_rdata",  d_rdata, 0);
    check("rst m_stall",  m_stall, 0);
    tick();
    rst = 1'b1;

    // 1. word store then word load
    m_op(1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    check("sw en",    g_en, 1);
    check("sw we",    g_we, 1);
    check("sw addr",  g_addr, 4);
    check("sw wdata", g_wdata, 32'hDEADBEEF);
    check("sw stall", g_stall, 1);
    check("sw lat",   lat + 1, 2);
    check("sw err",   g_err, 0);
    m_op(0, 2'b10, 0, 32'h10, 32'h0);
    check("lw we",    g_we, 0);
    check("lw lat",   lat + 1, 3);
    check("lw data",  g_rdata, 32'hDEADBEEF);

    // 2. byte/half read-modify-write and sub-word loads
    m_op(1, 2'b10, 0, 32'h10, 32'h11223344);
    wrb = wr_count;
    m_op(1, 2'b00, 0, 32'h11, 32'h000000A5);
    check("sb first we", g_we, 0);
    check("sb lat",      lat + 1, 4);
    check("sb writes",   wr_count - wrb, 1);
    check("sb mem",      mem[4], 32'h1122A544);
    m_op(0, 2'b00, 0, 32'h11, 32'h0);
    check("lb data",  g_rdata, 32'hFFFFFFA5);
    m_op(0, 2'b00, 1, 32'h11, 32'h0);
    check("lbu data", g_rdata, 32'h000000A5);
    m_op(1, 2'b01, 0, 32'h12, 32'h0000BEEF);
    check("sh lat",   lat + 1, 4);
    check("sh mem",   mem[4], 32'hBEEFA544);
    m_op(0, 2'b01, 0, 32'h12, 32'h0);
    check("lh data",  g_rdata, 32'hFFFFBEEF);
    m_op(0, 2'b01, 1, 32'h10, 32'h0);
    check("lhu data", g_rdata, 32'h0000A544);
    m_op(0, 2'b00, 0, 32'h13, 32'h0);
    check("lb3 data", g_rdata, 32'hFFFFFFBE);

    // 3. misaligned accesses
    wrb = wr_count;
    m_op(1, 2'b01, 0, 32'h13, 32'h00007777);
    check("mis sh en",  g_en, 0);
    check("mis sh lat", lat, 1);
    check("mis sh err", g_err, 1);
    check("mis sh wr",  wr_count - wrb, 0);
    check("mis sh mem", mem[4], 32'hBEEFA544);
    m_op(0, 2'b10, 0, 32'h12, 32'h0);
    check("mis lw en",  g_en, 0);
    check("mis lw err", g_err, 1);

    // 4. M and D both held from reset: M, D, M, D ...
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_req = 1; m_we = 0; m_size = 2'b10; m_unsigned = 0; m_addr = 32'h10;
    d_valid = 1; d_we = 0; d_addr = 32'h10;
    #1;
    for (int c = 0; c < 12; c++) begin
      check($sformatf("rr c%0d mem_en", c),   mem_en,   ((c % 3) == 0) ? 1 : 0);
      check($sformatf("rr c%0d d_ready", c),  d_ready,  ((c % 6) == 3) ? 1 : 0);
      check($sformatf("rr c%0d m_done", c),   m_done,   ((c % 6) == 2) ? 1 : 0);
      check($sformatf("rr c%0d d_rvalid", c), d_rvalid, ((c % 6) == 5) ? 1 : 0);
      if ((c % 6) == 2) check("rr m_rdata", m_rdata, 32'hBEEFA544);
      if ((c % 6) == 5) check("rr d_rdata", d_rdata, 32'hBEEFA544);
      tick(); #1;
    end
    m_req = 0; d_valid = 0;

    // 5. reset during MERGE of a byte store
    tick(); tick();
    m_req = 1; m_we = 1; m_size = 2'b00; m_unsigned = 0; m_addr = 32'h10; m_wdata = 32'h5A;
    #1;
    tick(); #1;
    tick(); #1;
    check("merge we",    mem_we, 1);
    check("merge wdata", mem_wdata, 32'hBEEFA55A);
    wrb = wr_count;
    rst = 1'b0;
    m_req = 0;
    #1;
    check("rstm mem_en",  mem_en, 0);
    check("rstm mem_we",  mem_we, 0);
    check("rstm m_done",  m_done, 0);
    check("rstm m_rdata", m_rdata, 0);
    tick(); tick();
    check("rstm writes", wr_count - wrb, 0);
    check("rstm mem",    mem[4], 32'hBEEFA544);
    rst = 1'b1;
    m_op(1, 2'b00, 0, 32'h10, 32'h5A);
    check("reissue lat", lat + 1, 4);
    check("reissue mem", mem[4], 32'hBEEFA55A);

    // 6. debug write, wrapped M load, wrapped debug read
    d_op(1, 32'h4, 32'hCAFEF00D);
    check("dw ready",  g_ready, 1);
    check("dw we",     g_we, 1);
    check("dw addr",   g_addr, 1);
    check("dw wdata",  g_wdata, 32'hCAFEF00D);
    check("dw rv1",    g_rv1, 0);
    check("dw done1",  g_done1, 0);
    check("dw rv2",    g_rv2, 0);
    m_op(0, 2'b10, 0, 32'h104, 32'h0);
    check("lw wrap",   g_rdata, 32'hCAFEF00D);
    d_op(0, 32'h104, 32'h0);
    check("dr ready",  g_ready, 1);
    check("dr we",     g_we, 0);
    check("dr addr",   g_addr, 1);
    check("dr rv1",    g_rv1, 0);
    check("dr rv2",    g_rv2, 1);
    check("dr data",   d_rdata, 32'hCAFEF00D);
    check("dr m_done", m_done, 0);
    check("m_rdata held", m_rdata, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
